// File: rtl/pwm_ramp_pkg.sv
// Shared types and helpers for the PWM duty ramp controller.
// Optional watchdog enabled with PWM_RAMP_WATCHDOG_EN.
package pwm_ramp_pkg;

  localparam int PWM_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    TRIP
  } state_t;

  // One slew step toward target; never wraps and never overshoots.
  function automatic logic [PWM_W-1:0] ramp_step(
    input logic [PWM_W-1:0] duty,
    input logic [PWM_W-1:0] target,
    input logic [PWM_W-1:0] step
  );
    logic [PWM_W:0]   sum;
    logic [PWM_W-1:0] dif;
    sum = {1'b0, duty} + {1'b0, step};
    dif = (duty > step) ? (duty - step) : '0;
    ramp_step = duty;
    if (duty < target) begin
      if (sum > {1'b0, target})
        ramp_step = target;
      else
        ramp_step = sum[PWM_W-1:0];
    end else if (duty > target) begin
      if (dif < target)
        ramp_step = target;
      else
        ramp_step = dif;
    end
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks.
// Count restarts only on reset, never on commands.
module tick_gen #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_last)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Command stage ahead of the PWM generator: slews duty toward target.
// Define PWM_RAMP_WATCHDOG_EN to add the command-loss watchdog.
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int               PRESCALE    = 1000,
  parameter int               STEP        = 16,
  parameter logic [PWM_W-1:0] INIT_PERIOD = 16'd999,
  parameter logic [PWM_W-1:0] SAFE_DUTY   = 16'd0,
  parameter int               WDT_TICKS   = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [PWM_W-1:0] cmd_period,
  input  logic [PWM_W-1:0] cmd_duty,
  output logic [PWM_W-1:0] period,
  output logic [PWM_W-1:0] duty,
  output logic             busy,
  output logic             wdt_trip
);

  localparam logic [PWM_W-1:0] STEP_L = PWM_W'(STEP);

  state_t           r_state;
  state_t           w_state;
  logic             r_ready;
  logic [PWM_W-1:0] r_period;
  logic [PWM_W-1:0] r_duty;
  logic [PWM_W-1:0] r_target;
  logic [PWM_W-1:0] w_period;
  logic [PWM_W-1:0] w_duty;
  logic [PWM_W-1:0] w_target;
  logic [PWM_W-1:0] w_step;
  logic [PWM_W-1:0] w_cmd_tgt;
  logic             w_accept;
  logic             w_tick;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .o_tick(w_tick)
  );

  assign w_accept  = cmd_valid & r_ready;
  assign w_step    = ramp_step(r_duty, r_target, STEP_L);
  assign w_cmd_tgt = (cmd_duty < cmd_period) ? cmd_duty : cmd_period;

`ifdef PWM_RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  localparam logic [WW-1:0] WDT_MAX = WW'(WDT_TICKS);

  logic [WW-1:0] r_wdt;
  logic [WW-1:0] w_wdt;
  logic          r_trip;
  logic          w_trip;
  logic          w_expire;

  assign w_expire = w_tick && (r_wdt == WDT_MAX - 1'b1);
  assign wdt_trip = r_trip;
`else
  assign wdt_trip = 1'b0;
`endif

  always_comb begin
    w_state  = r_state;
    w_period = r_period;
    w_duty   = r_duty;
    w_target = r_target;
`ifdef PWM_RAMP_WATCHDOG_EN
    w_wdt    = r_wdt;
    w_trip   = r_trip;
`endif
    if (w_accept) begin
      // Command wins over a coincident tick or expiry.
      w_period = cmd_period;
      w_target = w_cmd_tgt;
      if (r_duty > cmd_period)
        w_duty = cmd_period;
      w_state = (w_duty != w_cmd_tgt) ? RAMP : IDLE;
`ifdef PWM_RAMP_WATCHDOG_EN
      w_wdt  = '0;
      w_trip = 1'b0;
`endif
    end
`ifdef PWM_RAMP_WATCHDOG_EN
    else if (w_expire && r_state != TRIP) begin
      w_duty   = SAFE_DUTY;
      w_target = SAFE_DUTY;
      w_wdt    = WDT_MAX;
      w_trip   = 1'b1;
      w_state  = TRIP;
    end
`endif
    else if (w_tick) begin
`ifdef PWM_RAMP_WATCHDOG_EN
      if (r_wdt != WDT_MAX)
        w_wdt = r_wdt + 1'b1;
`endif
      if (r_state == RAMP) begin
        w_duty = w_step;
        if (w_step == r_target)
          w_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ready  <= 1'b0;
      r_period <= INIT_PERIOD;
      r_duty   <= SAFE_DUTY;
      r_target <= SAFE_DUTY;
    end else begin
      r_state  <= w_state;
      r_ready  <= 1'b1;
      r_period <= w_period;
      r_duty   <= w_duty;
      r_target <= w_target;
    end
  end

`ifdef PWM_RAMP_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt  <= '0;
      r_trip <= 1'b0;
    end else begin
      r_wdt  <= w_wdt;
      r_trip <= w_trip;
    end
  end
`endif

  assign cmd_ready = r_ready;
  assign period    = r_period;
  assign duty      = r_duty;
  assign busy      = (r_state == RAMP);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with PRESCALE=4, STEP=10, WDT_TICKS=8.
// Watchdog section follows PWM_RAMP_WATCHDOG_EN.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_period = '0;
  logic [15:0] cmd_duty = '0;
  logic [15:0] period;
  logic [15:0] duty;
  logic        busy;
  logic        wdt_trip;

  int n_tests = 0;
  int n_fail  = 0;
  int pc      = 0;

  pwm_ramp_ctrl #(
    .PRESCALE   (4),
    .STEP       (10),
    .INIT_PERIOD(16'd999),
    .SAFE_DUTY  (16'd0),
    .WDT_TICKS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_period(cmd_period),
    .cmd_duty  (cmd_duty),
    .period    (period),
    .duty      (duty),
    .busy      (busy),
    .wdt_trip  (wdt_trip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; pc models the prescaler count after the edge.
  task automatic cyc();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) pc = 0;
    else   pc = (pc == 3) ? 0 : pc + 1;
  endtask

  task automatic wait_tick();
    while (pc != 3) cyc();
    cyc();
  endtask

  task automatic send(input logic [15:0] p, input logic [15:0] d);
    cmd_valid  = 1'b1;
    cmd_period = p;
    cmd_duty   = d;
    cyc();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_period", period, 999);
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trip", wdt_trip, 0);
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_ready_last", cmd_ready, 0);
    cyc();
    chk("ready_after", cmd_ready, 1);

    send(16'd999, 16'd35);
    chk("up_busy", busy, 1);
    chk("up_d0", duty, 0);
    wait_tick(); chk("up_d10", duty, 10);
    chk("up_busy10", busy, 1);
    wait_tick(); chk("up_d20", duty, 20);
    wait_tick(); chk("up_d30", duty, 30);
    wait_tick(); chk("up_d35", duty, 35);
    chk("up_idle", busy, 0);

    send(16'd999, 16'd0);
    chk("dn_busy", busy, 1);
    wait_tick(); chk("dn_d25", duty, 25);
    wait_tick(); chk("dn_d15", duty, 15);
    wait_tick(); chk("dn_d5", duty, 5);
    wait_tick(); chk("dn_d0", duty, 0);
    chk("dn_idle", busy, 0);

    send(16'd999, 16'd35);
    wait_tick(); chk("rt_d10", duty, 10);
    wait_tick(); chk("rt_d20", duty, 20);
    send(16'd999, 16'd5);
    chk("rt_hold", duty, 20);
    chk("rt_busy", busy, 1);
    wait_tick(); chk("rt_d10b", duty, 10);
    wait_tick(); chk("rt_d5", duty, 5);
    chk("rt_idle", busy, 0);

    send(16'd999, 16'd35);
    wait_tick(); chk("cl_d15", duty, 15);
    wait_tick(); chk("cl_d25", duty, 25);
    wait_tick(); chk("cl_d35", duty, 35);
    send(16'd20, 16'd50);
    chk("cl_period", period, 20);
    chk("cl_duty", duty, 20);
    chk("cl_busy", busy, 0);
    wait_tick(); chk("cl_target", duty, 20);
    chk("cl_busy2", busy, 0);

    while (pc != 3) cyc();
    send(16'd999, 16'd60);
    chk("sim_duty", duty, 20);
    chk("sim_busy", busy, 1);
    chk("sim_period", period, 999);
    cyc(); cyc(); cyc();
    chk("sim_wait", duty, 20);
    cyc();
    chk("sim_step", duty, 30);

    rst = 1'b1;
    cyc();
    chk("mr_duty", duty, 0);
    chk("mr_period", period, 999);
    chk("mr_busy", busy, 0);
    chk("mr_ready", cmd_ready, 0);
    rst = 1'b0;
    cyc();
    chk("mr_ready1", cmd_ready, 1);
    chk("mr_duty1", duty, 0);

`ifdef PWM_RAMP_WATCHDOG_EN
    send(16'd999, 16'd35);
    repeat (7) wait_tick();
    chk("wd_hold", duty, 35);
    chk("wd_notrip", wdt_trip, 0);
    wait_tick();
    chk("wd_duty", duty, 0);
    chk("wd_trip", wdt_trip, 1);
    chk("wd_period", period, 999);
    chk("wd_busy", busy, 0);
    wait_tick();
    chk("wd_sticky", wdt_trip, 1);
    send(16'd999, 16'd30);
    chk("wd_clear", wdt_trip, 0);
    chk("wd_rbusy", busy, 1);
    wait_tick(); chk("wd_d10", duty, 10);
    wait_tick(); chk("wd_d20", duty, 20);
    wait_tick(); chk("wd_d30", duty, 30);
    chk("wd_idle", busy, 0);
`else
    send(16'd999, 16'd35);
    repeat (10) wait_tick();
    chk("nw_duty", duty, 35);
    chk("nw_trip", wdt_trip, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Command stage sitting directly upstream of the PWM generator. Accepts period/duty commands over a valid/ready handshake and drives the PWM block's `period` and `duty` inputs. Slews `duty` toward the commanded target at a bounded rate, so motor and servo loads never see step changes. An optional watchdog forces a safe duty when commands stop arriving.

## Interface
Parameters:
- `PRESCALE`, 1000: clk cycles per ramp tick (≥2).
- `STEP`, 16: max duty change per tick, in duty LSBs (1..65535).
- `INIT_PERIOD`, 16'd999: `period` value after reset.
- `SAFE_DUTY`, 16'd0: `duty` value after reset and on watchdog trip.
- `WDT_TICKS`, 500: ticks without an accepted command before trip (watchdog builds only).

Ports:
- `clk`, in, 1: the single clock; everything is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_period`, in, 16: requested PWM period.
- `cmd_duty`, in, 16: requested target duty.
- `period`, out, 16: to PWM `period`, registered.
- `duty`, out, 16: to PWM `duty`, registered.
- `busy`, out, 1: ramp in progress (`duty` ≠ target).
- `wdt_trip`, out, 1: watchdog has fired; sticky until the next accepted command.

## Operation
- Accept condition: `cmd_valid && cmd_ready`. `cmd_ready` is 1 in every state outside reset.
- On accept:
  - `period <= cmd_period`.
  - `target <= min(cmd_duty, cmd_period)`.
  - If current `duty > cmd_period`, then `duty <= cmd_period` in the same update. This keeps duty ≤ period at all times.
- Ramp, applied on each tick while `duty ≠ target`:
  - `duty < target`: `duty <= min(duty + STEP, target)`.
  - `duty > target`: `duty <= max(duty − STEP, target)`.
  - Use a 17-bit intermediate for the add and a saturating subtract. No wrap is allowed.
- States:
  - IDLE (`duty == target`): moves to RAMP on an accept that makes `duty ≠ target`.
  - RAMP: moves to IDLE when the step lands on target.
  - TRIP: watchdog builds only. Leaves to RAMP or IDLE on the next accept.
- `busy` = (state == RAMP).
- A new command during RAMP retargets immediately. The ramp continues from the current `duty`.

## Timing
- Reset values: `period = INIT_PERIOD`, `duty = SAFE_DUTY`, `target = SAFE_DUTY`, `cmd_ready = 0`, `busy = 0`, `wdt_trip = 0`, state IDLE, prescaler = 0, watchdog count = 0.
- `cmd_ready` goes to 1 on the first cycle after `rst` deasserts.
- Prescaler: free-running count 0..`PRESCALE`−1. `tick` is asserted for the one cycle when count == `PRESCALE`−1, then the count wraps to 0. Commands do not reset the prescaler.
- Accept latency: new `period` and any clamped `duty` appear on the outputs 1 cycle after the accept edge. The first ramp step happens at the next tick strictly after the accept.
- Accept and tick in the same cycle: the command wins and no step is applied that cycle.
- `rst` asserted mid-ramp returns everything to reset values on that edge. No partial step is applied.

## Configuration
- Macro: `PWM_RAMP_WATCHDOG_EN`.
- Defined:
  - A watchdog counter increments once per tick and clears on every accept.
  - When the count reaches `WDT_TICKS`, on that same edge: `duty <= SAFE_DUTY` (immediate, not ramped), `target <= SAFE_DUTY`, `wdt_trip <= 1`, state TRIP. `period` is held.
  - The counter saturates while in TRIP.
  - Accept and expiry in the same cycle: the accept wins and the counter clears.
- Undefined: no counter, no TRIP state, `wdt_trip` tied to 0.

## Structure
- Package `pwm_ramp_pkg`:
  - State enum `{IDLE, RAMP, TRIP}`.
  - Constant `PWM_W = 16`.
  - Function `ramp_step(duty, target, step)`, returning the saturated next duty.
- One sub-module, `tick_gen`: parameterised prescaler producing the single-cycle `tick`. Same `clk`/`rst`.
- All remaining logic is in `pwm_ramp_ctrl`.

## Test plan
Run with `PRESCALE=4`, `STEP=10`, `WDT_TICKS=8`, `INIT_PERIOD=999`, `SAFE_DUTY=0`.
- Reset: hold `rst` for 3 cycles, then release. Check `period=999`, `duty=0`, `busy=0`; `cmd_ready` is 0 during reset and 1 on the first cycle after.
- Ramp up: accept (period 999, duty 35). Check `busy=1` and `duty` goes 10, 20, 30, 35 on consecutive ticks, then `busy=0`.
- Retarget down mid-ramp: at `duty=20`, accept (999, 5). Check `duty` goes 10, then 5 on the next two ticks, with no over- or undershoot.
- Period clamp: with `duty=35`, accept (period 20, duty 50). One cycle later check `period=20`, `duty=20`, target 20, `busy=0`.
- Simultaneous events: accept in the same cycle as a tick. Check `duty` is unchanged that cycle and the first step occurs one `PRESCALE` later.
- Watchdog (with `PWM_RAMP_WATCHDOG_EN`): hold at `duty=35` with no commands for 8 ticks. Check `duty=0` and `wdt_trip=1` on the 8th tick, with `period` unchanged. A subsequent accept of (999, 30) clears `wdt_trip` and ramps back up.
